// File: rtl/cv32e40p_x_disp_pkg.sv
// Shared types for the X-interface dispatcher: coprocessor index, request/response bundles.
// The localparams here size the shared types; the top's parameters default to them.
package cv32e40p_x_disp_pkg;

    localparam int CP_NUM    = 2;
    localparam int CP_XLEN   = 32;
    localparam int CP_NUM_RS = 3;
    localparam int CP_IDX_W  = (CP_NUM > 1) ? $clog2(CP_NUM) : 1;

    typedef logic [CP_IDX_W-1:0] cp_idx_t;

    typedef struct packed {
        logic [31:0]                  instr;
        logic [CP_NUM_RS*CP_XLEN-1:0] rs;
        logic [CP_NUM_RS-1:0]         rs_valid;
        logic                         rd_clean;
    } x_req_t;

    typedef struct packed {
        logic [4:0]         rd;
        logic [CP_XLEN-1:0] data;
        logic               dualwb;
        logic               error;
    } x_rsp_t;

    function automatic logic [3:0] count_ones8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

endpackage

// File: rtl/cv32e40p_x_id_fifo.sv
// In-order FIFO of coprocessor indices that owe a writeback response.
module cv32e40p_x_id_fifo
    import cv32e40p_x_disp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  cp_idx_t                    push_id,
    input  logic                       pop,
    output cp_idx_t                    head_id,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    cp_idx_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head_id = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/cv32e40p_x_dispatcher.sv
// Fans one core X-interface out to NUM_COPROC coprocessors; picks the lowest accepting
// coprocessor per offload and returns writeback responses strictly in issue order.
module cv32e40p_x_dispatcher
    import cv32e40p_x_disp_pkg::*;
#(
    parameter int NUM_COPROC = CP_NUM,
    parameter int DEPTH      = 4,
    parameter int X_NUM_RS   = CP_NUM_RS,
    parameter int XLEN       = CP_XLEN
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        x_valid_i,
    output logic                        x_ready_o,
    input  logic [31:0]                 x_instr_data_i,
    input  logic [X_NUM_RS*XLEN-1:0]    x_rs_i,
    input  logic [X_NUM_RS-1:0]         x_rs_valid_i,
    input  logic                        x_rd_clean_i,
    output logic                        x_accept_o,
    output logic                        x_is_mem_op_o,
    output logic                        x_writeback_o,
    output logic                        x_rvalid_o,
    input  logic                        x_rready_i,
    output logic [4:0]                  x_rd_o,
    output logic [XLEN-1:0]             x_data_o,
    output logic                        x_dualwb_o,
    output logic                        x_error_o,
    output logic [NUM_COPROC-1:0]       cp_valid_o,
    input  logic [NUM_COPROC-1:0]       cp_ready_i,
    output logic [31:0]                 cp_instr_data_o,
    output logic [X_NUM_RS*XLEN-1:0]    cp_rs_o,
    output logic [X_NUM_RS-1:0]         cp_rs_valid_o,
    output logic                        cp_rd_clean_o,
    input  logic [NUM_COPROC-1:0]       cp_accept_i,
    input  logic [NUM_COPROC-1:0]       cp_is_mem_op_i,
    input  logic [NUM_COPROC-1:0]       cp_writeback_i,
    input  logic [NUM_COPROC-1:0]       cp_rvalid_i,
    output logic [NUM_COPROC-1:0]       cp_rready_o,
    input  logic [NUM_COPROC*5-1:0]     cp_rd_i,
    input  logic [NUM_COPROC*XLEN-1:0]  cp_data_i,
    input  logic [NUM_COPROC-1:0]       cp_dualwb_i,
    input  logic [NUM_COPROC-1:0]       cp_error_i,
    output logic [$clog2(DEPTH+1)-1:0]  outstanding_o,
    output logic                        multi_accept_o,
    output logic                        spurious_rsp_o
);
    x_req_t req;
    x_rsp_t rsp;

    logic                  full, empty, push, pop, any_acc;
    cp_idx_t               head, winner;
    logic [NUM_COPROC-1:0] rdy_seen, acc_seen, mem_seen, wb_seen;
    logic [NUM_COPROC-1:0] acc_eff, mem_eff, wb_eff, stale;
    logic [NUM_COPROC-1:0][3:0] stale_cnt;
    logic [3:0]            n_acc;

    assign req = '{instr: x_instr_data_i, rs: x_rs_i, rs_valid: x_rs_valid_i,
                   rd_clean: x_rd_clean_i};
    assign cp_instr_data_o = req.instr;
    assign cp_rs_o         = req.rs;
    assign cp_rs_valid_o   = req.rs_valid;
    assign cp_rd_clean_o   = req.rd_clean;

    // A coprocessor that already answered is not offered the same request again.
    assign cp_valid_o = (rst_i | full | ~x_valid_i) ? '0 : ~rdy_seen;
    assign x_ready_o  = ~rst_i & x_valid_i & ~full & (&(rdy_seen | cp_ready_i));

    always_comb begin
        acc_eff = '0;
        mem_eff = '0;
        wb_eff  = '0;
        winner  = '0;
        any_acc = 1'b0;
        for (int i = NUM_COPROC-1; i >= 0; i--) begin
            acc_eff[i] = rdy_seen[i] ? acc_seen[i] : (cp_ready_i[i] & cp_accept_i[i]);
            mem_eff[i] = rdy_seen[i] ? mem_seen[i] : cp_is_mem_op_i[i];
            wb_eff[i]  = rdy_seen[i] ? wb_seen[i]  : cp_writeback_i[i];
            if (acc_eff[i]) begin
                winner  = cp_idx_t'(i);
                any_acc = 1'b1;
            end
        end
        n_acc = count_ones8(8'(acc_eff));
    end

    assign x_accept_o     = x_ready_o & any_acc;
    assign x_is_mem_op_o  = x_accept_o & mem_eff[winner];
    assign x_writeback_o  = x_accept_o & wb_eff[winner];
    assign multi_accept_o = x_ready_o & (n_acc > 4'd1);
    assign push           = x_accept_o & x_writeback_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || x_ready_o) begin
            rdy_seen <= '0;
            acc_seen <= '0;
            mem_seen <= '0;
            wb_seen  <= '0;
        end else begin
            for (int i = 0; i < NUM_COPROC; i++) begin
                if (cp_valid_o[i] && cp_ready_i[i]) begin
                    rdy_seen[i] <= 1'b1;
                    acc_seen[i] <= cp_accept_i[i];
                    mem_seen[i] <= cp_is_mem_op_i[i];
                    wb_seen[i]  <= cp_writeback_i[i];
                end
            end
        end
    end

    cv32e40p_x_id_fifo #(.DEPTH(DEPTH)) u_id_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (push),
        .push_id (winner),
        .pop     (pop),
        .head_id (head),
        .full    (full),
        .empty   (empty),
        .count   (outstanding_o)
    );

    assign x_rvalid_o = ~rst_i & ~empty & cp_rvalid_i[head];

    always_comb begin
        rsp = '0;
        if (x_rvalid_o) begin
            rsp.rd     = cp_rd_i[int'(head)*5 +: 5];
            rsp.data   = cp_data_i[int'(head)*XLEN +: XLEN];
            rsp.dualwb = cp_dualwb_i[head];
            rsp.error  = cp_error_i[head];
        end
    end

    assign x_rd_o     = rsp.rd;
    assign x_data_o   = rsp.data;
    assign x_dualwb_o = rsp.dualwb;
    assign x_error_o  = rsp.error;

    // Only the head may complete; everyone else is back-pressured.
    always_comb begin
        cp_rready_o = '0;
        if (!rst_i && !empty && x_rready_i) cp_rready_o[head] = 1'b1;
    end

    // The first beat of a dual writeback leaves the entry in place for the second.
    assign pop = x_rvalid_o & x_rready_i & ~rsp.dualwb;

    always_comb begin
        stale          = '0;
        spurious_rsp_o = 1'b0;
        for (int i = 0; i < NUM_COPROC; i++) begin
            stale[i] = cp_rvalid_i[i] & (empty | (cp_idx_t'(i) != head));
            if (!rst_i && stale[i] && stale_cnt[i] == 4'hF) spurious_rsp_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_COPROC; i++) begin
            if (rst_i || !stale[i]) stale_cnt[i] <= '0;
            else                    stale_cnt[i] <= stale_cnt[i] + 4'd1;
        end
    end

endmodule

// File: tb/tb_cv32e40p_x_dispatcher.sv
// Scoreboard bench: the issue path predicts the winner and queues expected response beats;
// a monitor compares every core-side response beat in issue order.
module tb_cv32e40p_x_dispatcher;
    localparam int N = 2, DEPTH = 4, NRS = 3, XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i, x_valid_i, x_ready_o, x_rd_clean_i;
    logic [31:0] x_instr_data_i, cp_instr_data_o;
    logic [NRS*XLEN-1:0] x_rs_i, cp_rs_o;
    logic [NRS-1:0] x_rs_valid_i, cp_rs_valid_o;
    logic x_accept_o, x_is_mem_op_o, x_writeback_o, x_rvalid_o, x_rready_i;
    logic [4:0] x_rd_o;
    logic [XLEN-1:0] x_data_o;
    logic x_dualwb_o, x_error_o, cp_rd_clean_o;
    logic [N-1:0] cp_valid_o, cp_ready_i, cp_accept_i, cp_is_mem_op_i, cp_writeback_i;
    logic [N-1:0] cp_rvalid_i, cp_rready_o, cp_dualwb_i, cp_error_i;
    logic [N*5-1:0] cp_rd_i;
    logic [N*XLEN-1:0] cp_data_i;
    logic [$clog2(DEPTH+1)-1:0] outstanding_o;
    logic multi_accept_o, spurious_rsp_o;

    cv32e40p_x_dispatcher #(.NUM_COPROC(N), .DEPTH(DEPTH), .X_NUM_RS(NRS), .XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .x_instr_data_i(x_instr_data_i),
        .x_rs_i(x_rs_i), .x_rs_valid_i(x_rs_valid_i), .x_rd_clean_i(x_rd_clean_i),
        .x_accept_o(x_accept_o), .x_is_mem_op_o(x_is_mem_op_o), .x_writeback_o(x_writeback_o),
        .x_rvalid_o(x_rvalid_o), .x_rready_i(x_rready_i), .x_rd_o(x_rd_o), .x_data_o(x_data_o),
        .x_dualwb_o(x_dualwb_o), .x_error_o(x_error_o),
        .cp_valid_o(cp_valid_o), .cp_ready_i(cp_ready_i), .cp_instr_data_o(cp_instr_data_o),
        .cp_rs_o(cp_rs_o), .cp_rs_valid_o(cp_rs_valid_o), .cp_rd_clean_o(cp_rd_clean_o),
        .cp_accept_i(cp_accept_i), .cp_is_mem_op_i(cp_is_mem_op_i),
        .cp_writeback_i(cp_writeback_i), .cp_rvalid_i(cp_rvalid_i), .cp_rready_o(cp_rready_o),
        .cp_rd_i(cp_rd_i), .cp_data_i(cp_data_i), .cp_dualwb_i(cp_dualwb_i),
        .cp_error_i(cp_error_i), .outstanding_o(outstanding_o),
        .multi_accept_o(multi_accept_o), .spurious_rsp_o(spurious_rsp_o)
    );

    typedef struct { logic [4:0] rd; logic [XLEN-1:0] data; logic dualwb; logic error; } beat_t;

    beat_t cpq [N][$];   // beats each coprocessor model still has to deliver
    beat_t expq[$];      // beats the core must see, in issue order
    int checks = 0, errors = 0;
    logic [N-1:0] rsp_en = '0, force_rv = '0;
    bit rnd = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Coprocessor response models: hold rvalid until taken, then move to the next beat.
    initial begin
        logic [N-1:0] hs;
        beat_t b;
        cp_rvalid_i = '0; cp_rd_i = '0; cp_data_i = '0; cp_dualwb_i = '0; cp_error_i = '0;
        x_rready_i = 1'b1;
        forever begin
            @(negedge clk);
            hs = cp_rvalid_i & cp_rready_o;
            @(posedge clk); #1;
            x_rready_i = !rnd || ($urandom_range(3) != 0);
            for (int i = 0; i < N; i++) begin
                if (hs[i] && cpq[i].size() > 0) void'(cpq[i].pop_front());
                if (cpq[i].size() == 0) cp_rvalid_i[i] = 1'b0;
                else if (!(cp_rvalid_i[i] && !hs[i]))
                    cp_rvalid_i[i] = rsp_en[i] && (!rnd || $urandom_range(2) != 0);
                if (cpq[i].size() > 0) begin
                    b = cpq[i][0];
                    cp_rd_i[i*5 +: 5] = b.rd; cp_data_i[i*XLEN +: XLEN] = b.data;
                    cp_dualwb_i[i] = b.dualwb; cp_error_i[i] = b.error;
                end else begin
                    cp_rd_i[i*5 +: 5] = '0; cp_data_i[i*XLEN +: XLEN] = '0;
                    cp_dualwb_i[i] = 1'b0; cp_error_i[i] = 1'b0;
                end
                if (force_rv[i]) cp_rvalid_i[i] = 1'b1;
            end
        end
    end

    // Response monitor.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (x_rvalid_o && x_rready_i) begin
                if (expq.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    b = expq.pop_front();
                    chk("rsp_data", x_data_o, b.data);
                    chk("rsp_rd", x_rd_o, b.rd);
                    chk("rsp_dualwb", x_dualwb_o, b.dualwb);
                    chk("rsp_error", x_error_o, b.error);
                end
            end
        end
    end

    // One offload: coprocessor i raises ready from cycle d_i on with a fixed decision.
    task automatic issue(input logic [N-1:0] acc, wb, mem, input int d0, d1, input bit dual,
                         input logic [XLEN-1:0] dat, input bit chkv, input int budget,
                         output int lat);
        int d[N];
        int cyc = 0, w;
        bit done = 0;
        logic [N-1:0] ev;
        beat_t b;
        d[0] = d0; d[1] = d1; lat = -1;
        @(posedge clk); #1;
        x_valid_i = 1'b1; x_instr_data_i = $urandom;
        x_rs_i = {$urandom, $urandom, $urandom}; x_rs_valid_i = 3'($urandom);
        x_rd_clean_i = 1'($urandom);
        cp_accept_i = acc; cp_writeback_i = wb; cp_is_mem_op_i = mem;
        while (!done) begin
            for (int i = 0; i < N; i++) cp_ready_i[i] = (cyc >= d[i]);
            @(negedge clk);
            if (chkv) begin
                for (int i = 0; i < N; i++) ev[i] = (cyc <= d[i]);
                chk("cp_valid", cp_valid_o, ev);
            end
            if (x_ready_o) begin
                done = 1; lat = cyc; w = -1;
                for (int i = N-1; i >= 0; i--) if (acc[i]) w = i;
                chk("accept", x_accept_o, w >= 0);
                chk("writeback", x_writeback_o, (w >= 0) ? wb[w] : 1'b0);
                chk("is_mem", x_is_mem_op_o, (w >= 0) ? mem[w] : 1'b0);
                chk("multi", multi_accept_o, $countones(acc) >= 2);
                chk("bcast", {cp_instr_data_o === x_instr_data_i, cp_rs_o === x_rs_i,
                              cp_rd_clean_o === x_rd_clean_i}, 3'b111);
                if (w >= 0 && wb[w]) begin
                    b.rd = 5'($urandom); b.data = dat; b.error = rnd ? 1'($urandom) : 1'b0;
                    b.dualwb = dual;
                    cpq[w].push_back(b); expq.push_back(b);
                    if (dual) begin
                        b.rd = 5'($urandom); b.data = ~dat; b.dualwb = 1'b0;
                        cpq[w].push_back(b); expq.push_back(b);
                    end
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (!done && cyc > budget) begin
                chk("req_timeout", 1, 0);
                done = 1;
            end
        end
        x_valid_i = 1'b0; cp_ready_i = '0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (expq.size() != 0 && k < budget) begin
            @(negedge clk); #2;
            k++;
        end
        chk("drain_left", expq.size(), 0);
        @(negedge clk);
        chk("drain_outstanding", outstanding_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, first, npulse;
        rst_i = 1'b1; x_valid_i = 1'b1; cp_ready_i = '1; cp_accept_i = '1;
        cp_writeback_i = '1; cp_is_mem_op_i = '0;
        x_instr_data_i = '0; x_rs_i = '0; x_rs_valid_i = '0; x_rd_clean_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cp_valid", cp_valid_o, 0);
        chk("rst_ready_accept", {x_ready_o, x_accept_o, multi_accept_o}, 0);
        chk("rst_rsp", {x_rvalid_o, cp_rready_o}, 0);
        chk("rst_outstanding", outstanding_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0; x_valid_i = 1'b0; cp_ready_i = '0;

        // Both ready at once, only cp1 accepts with writeback.
        @(negedge clk); rsp_en = '1;
        issue(2'b10, 2'b11, 2'b00, 0, 0, 0, 32'h1234_5678, 1, 20, lat);
        chk("same_cycle_lat", lat, 0);
        chk("outstanding_one", outstanding_o, 1);
        drain(50);

        // cp0 answers immediately, cp1 after three cycles.
        issue(2'b00, 2'b00, 2'b00, 0, 3, 0, 0, 1, 20, lat);
        chk("late_ready_lat", lat, 3);

        // Responses return in issue order even if the younger one is ready first.
        @(negedge clk); rsp_en = '0;
        issue(2'b10, 2'b10, 2'b00, 0, 0, 0, 32'hB, 0, 20, lat);
        issue(2'b01, 2'b01, 2'b00, 0, 0, 0, 32'hA, 0, 20, lat);
        @(negedge clk); rsp_en = 2'b01;
        repeat (4) begin
            @(negedge clk);
            chk("order_hold", {x_rvalid_o, cp_rready_o[0]}, 2'b00);
        end
        rsp_en = '1;
        drain(50);

        // Four outstanding writebacks fill the FIFO; the fifth waits for a pop.
        @(negedge clk); rsp_en = '0;
        for (int k = 0; k < 4; k++)
            issue((k % 2) ? 2'b10 : 2'b01, 2'b11, 2'b00, 0, 0, 0, 32'(k + 100), 0, 20, lat);
        chk("full_count", outstanding_o, 4);
        fork
            issue(2'b01, 2'b01, 2'b00, 0, 0, 0, 32'h55, 0, 40, lat);
            begin
                @(posedge clk); #1;
                repeat (3) begin
                    @(negedge clk);
                    chk("full_block", {x_ready_o, cp_valid_o}, 0);
                end
                rsp_en = '1;
            end
        join
        chk("full_release_lat", lat, 4);
        drain(60);

        // Two acceptors: lowest index wins; dual writeback is two beats, one entry.
        issue(2'b11, 2'b11, 2'b10, 0, 0, 1, 32'hD00D, 0, 20, lat);
        @(negedge clk);
        chk("multi_pulse_end", multi_accept_o, 0);
        drain(50);

        // Reset while three entries are outstanding and a request is half collected.
        @(negedge clk); rsp_en = '0;
        for (int k = 0; k < 3; k++) issue(2'b01, 2'b01, 2'b00, 0, 0, 0, 32'(k), 0, 20, lat);
        @(posedge clk); #1;
        x_valid_i = 1'b1; cp_ready_i = 2'b01; cp_accept_i = 2'b00;
        @(negedge clk);
        chk("half_cp_valid", cp_valid_o, 2'b11);
        @(posedge clk); #1;
        cp_ready_i = '0; rst_i = 1'b1;
        @(negedge clk);
        chk("midrst_block", {x_ready_o, cp_valid_o}, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("midrst_outstanding", outstanding_o, 0);
        chk("midrst_sticky_clear", cp_valid_o, 2'b11);
        x_valid_i = 1'b0;
        for (int i = 0; i < N; i++) cpq[i].delete();
        expq.delete();

        // Stray rvalid with nothing outstanding: flag on the 16th cycle, once.
        @(negedge clk); force_rv = 2'b01;
        first = 0; npulse = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (spurious_rsp_o) begin
                npulse++;
                if (first == 0) first = k;
            end
        end
        force_rv = '0;
        chk("spurious_cycle", first, 16);
        chk("spurious_pulses", npulse, 1);
        repeat (2) @(negedge clk);

        // Randomized traffic against the issue-order model.
        rnd = 1'b1; rsp_en = '1;
        for (int k = 0; k < 40; k++)
            issue(2'($urandom), 2'($urandom), 2'($urandom), $urandom_range(3),
                  $urandom_range(3), 1'($urandom), $urandom, 0, 300, lat);
        drain(500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
